vc_test_rand_delay_source_ctrl: RTL and testbench
=================================================

// Module: vc_test_rand_delay_source_ctrl
//
// PURPOSE
//  Parametrised successor to the random-delay test source. Streams a preloaded message table
//  over a val/rdy port with selectable inter-message delay: none, fixed, LFSR-random or burst.
//  Delays come from a seeded LFSR, not $random, so runs are reproducible per seed.
//  Sits in unit-test harnesses in front of a DUT input port, paired with a test sink.
//
// PARAMETERS
//  p_msg_sz    8       message width in bits
//  p_mem_sz    1024    message table depth; the bench preloads table m[0:p_mem_sz-1] hierarchically
//  p_max_delay 0       upper bound of the random delay in cycles (inclusive)
//  p_burst_len 4       messages per burst in burst mode; range >=1
//  p_seed      16'hACE1  LFSR reset value; must be nonzero
//
// PORTS
//  clk         in   1                      clock; all logic on the rising edge
//  reset       in   1                      one clock; reset is asynchronous and active-low
//  mode        in   2                      0 = no delay, 1 = fixed, 2 = random, 3 = burst
//  fixed_delay in   8                      delay in cycles for mode 1
//  num_msgs    in   clog2(p_mem_sz)+1      number of messages to send; clamped to p_mem_sz
//  val         out  1                      message valid
//  rdy         in   1                      sink ready
//  msg         out  p_msg_sz               message payload, equal to m[idx]
//  count       out  clog2(p_mem_sz)+1      messages accepted so far
//  done        out  1                      all num_msgs messages accepted
//
// BEHAVIOUR
//  Reset values (reset==0, async): state=INIT, idx=0, count=0, dcnt=0, lfsr=p_seed.
//   Outputs at reset: val=0, done=0, msg=0.
//  LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances every cycle while reset==1.
//  Delay draw D:
//   - mode 0: D = 0.
//   - mode 1: D = fixed_delay.
//   - mode 2: D = lfsr % (p_max_delay+1).
//   - mode 3: D = lfsr % (p_max_delay+1) at the start of each group of p_burst_len messages, else D = 0.
//   - mode and fixed_delay are sampled only at draw time.
//  FSM:
//   - INIT: on the first edge after reset release, if N==0 go to DONE. Otherwise draw D;
//     if D==0 go to SEND, else go to WAIT with dcnt=D-1.
//   - WAIT: val=0. dcnt decrements each cycle; when dcnt==0, go to SEND.
//   - SEND: val=1, msg=m[idx].
//     - rdy==0: hold; msg and val stay stable.
//     - val&rdy: idx++ and count++, then draw the next D.
//     - After that, if count+1==N go to DONE; else if D==0 stay in SEND (back-to-back, 1 msg/cycle);
//       else go to WAIT.
//   - DONE: val=0, done=1, msg holds the last value; stays until reset.
//  Latency: the first val rises D+1 cycles after reset release; a delay of D inserts exactly D val-low cycles.
//  N = min(num_msgs, p_mem_sz), sampled in INIT and held.
//  N==0: done=1 one cycle after reset release; val never asserts.
//  val never depends combinationally on rdy (no comb path rdy->val/msg).
//  count saturates at N and idx never exceeds p_mem_sz-1.
//  Reset mid-operation: all state returns to reset values; the sequence restarts identically for the same seed.
//  Table contents are never modified by this block.
//
// TESTING
//  T1 mode=0, N=6, m={aa,bb,cc,dd,ee,ff}, rdy=1 -> val high 6 consecutive cycles; done on cycle 7.
//  T2 mode=1, fixed_delay=3, N=3, rdy=1 -> exactly 3 val-low cycles before each msg; done at cycle 13.
//  T3 mode=2, p_max_delay=10, N=6, sink with random rdy
//     -> msgs arrive in order aa..ff; msg stable while val&!rdy; done within 500 cycles.
//  T4 mode=3, p_burst_len=4, N=8 -> two groups of 4 back-to-back msgs, each preceded by one random gap.
//  T5 num_msgs=0 -> done=1 one cycle after reset release; val=0 throughout.
//  T6 reset pulled low after 3 msgs in mode 2, then released
//     -> val/done/count clear immediately; the replay matches the first run's delay sequence cycle-exact.

Source files
------------

// File: rtl/vc_test_rand_delay_source_ctrl.sv
// Test source that streams a preloaded message table over val/rdy with a selectable
// inter-message delay (none, fixed, seeded-LFSR random, or random-gap bursts).
module vc_test_rand_delay_source_ctrl #(
  parameter int unsigned p_msg_sz    = 8,
  parameter int unsigned p_mem_sz    = 1024,
  parameter int unsigned p_max_delay = 0,
  parameter int unsigned p_burst_len = 4,
  parameter logic [15:0] p_seed      = 16'hACE1,
  localparam int unsigned CntW       = $clog2(p_mem_sz) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          mode,
  input  logic [7:0]          fixed_delay,
  input  logic [CntW-1:0]     num_msgs,
  output logic                val,
  input  logic                rdy,
  output logic [p_msg_sz-1:0] msg,
  output logic [CntW-1:0]     count,
  output logic                done
);

  localparam int unsigned IdxW     = (p_mem_sz > 1) ? $clog2(p_mem_sz) : 1;
  localparam int unsigned RndW     = (p_max_delay > 0) ? $clog2(p_max_delay + 1) : 1;
  localparam int unsigned DlyW     = (RndW > 8) ? RndW : 8;
  localparam int unsigned BcW      = (p_burst_len > 1) ? $clog2(p_burst_len) : 1;
  localparam logic [BcW-1:0]  BcLast   = BcW'(p_burst_len - 1);
  localparam logic [CntW-1:0] MemSzC   = CntW'(p_mem_sz);
  localparam logic [15:0]     LfsrTaps = 16'hB400;

  typedef enum logic [1:0] {
    StInit,
    StWait,
    StSend,
    StDone
  } state_e;

  // Message table; loaded from outside the block, only ever read here.
  logic [p_msg_sz-1:0] m [0:p_mem_sz-1];

  state_e              r_state, w_state_nxt;
  logic [IdxW-1:0]     r_idx, w_idx_nxt;
  logic [CntW-1:0]     r_count, w_count_nxt;
  logic [CntW-1:0]     r_n, w_n_nxt;
  logic [DlyW-1:0]     r_dcnt, w_dcnt_nxt;
  logic [BcW-1:0]      r_bcnt, w_bcnt_nxt;
  logic [15:0]         r_lfsr, w_lfsr_nxt;
  logic [p_msg_sz-1:0] r_msg, w_msg_nxt;

  logic                w_fire;
  logic                w_grp_start;
  logic [DlyW-1:0]     w_rand;
  logic [DlyW-1:0]     w_draw;

  assign w_fire     = (r_state == StSend) && rdy;
  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LfsrTaps : 16'h0000);
  assign w_rand     = DlyW'(32'(r_lfsr) % (p_max_delay + 1));

  // Position within the current burst group, counted per accepted message.
  always_comb begin
    w_bcnt_nxt = r_bcnt;
    if (w_fire) begin
      w_bcnt_nxt = (r_bcnt == BcLast) ? '0 : r_bcnt + 1'b1;
    end
  end

  assign w_grp_start = (w_bcnt_nxt == '0);

  always_comb begin
    w_draw = '0;
    case (mode)
      2'd0:    w_draw = '0;
      2'd1:    w_draw = DlyW'(fixed_delay);
      2'd2:    w_draw = w_rand;
      2'd3:    w_draw = w_grp_start ? w_rand : '0;
      default: w_draw = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_count_nxt = r_count;
    w_n_nxt     = r_n;
    w_dcnt_nxt  = r_dcnt;
    w_msg_nxt   = r_msg;
    case (r_state)
      StInit: begin
        w_n_nxt = (num_msgs > MemSzC) ? MemSzC : num_msgs;
        if (w_n_nxt == '0) begin
          w_state_nxt = StDone;
        end else if (w_draw == '0) begin
          w_state_nxt = StSend;
          w_msg_nxt   = m[r_idx];
        end else begin
          w_state_nxt = StWait;
          w_dcnt_nxt  = w_draw - 1'b1;
        end
      end
      StWait: begin
        if (r_dcnt == '0) begin
          w_state_nxt = StSend;
          w_msg_nxt   = m[r_idx];
        end else begin
          w_dcnt_nxt = r_dcnt - 1'b1;
        end
      end
      StSend: begin
        if (rdy) begin
          w_count_nxt = r_count + 1'b1;
          // idx stays on the last entry so it never runs past the table.
          if (w_count_nxt == r_n) begin
            w_state_nxt = StDone;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
            if (w_draw == '0) begin
              w_msg_nxt = m[w_idx_nxt];
            end else begin
              w_state_nxt = StWait;
              w_dcnt_nxt  = w_draw - 1'b1;
            end
          end
        end
      end
      StDone: begin
        w_state_nxt = StDone;
      end
      default: begin
        w_state_nxt = StInit;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StInit;
      r_idx   <= '0;
      r_count <= '0;
      r_n     <= '0;
      r_dcnt  <= '0;
      r_bcnt  <= '0;
      r_lfsr  <= p_seed;
      r_msg   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_count <= w_count_nxt;
      r_n     <= w_n_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_msg   <= w_msg_nxt;
    end
  end

  // Outputs come straight from registers: no combinational path from rdy.
  assign val   = (r_state == StSend);
  assign done  = (r_state == StDone);
  assign msg   = r_msg;
  assign count = r_count;

endmodule

// File: tb/tb_vc_test_rand_delay_source_ctrl.sv
// Bench for vc_test_rand_delay_source_ctrl: per-cycle comparison against an event-level
// model (message ready times from drawn delays) plus hand-computed cycle expectations.
module tb_vc_test_rand_delay_source_ctrl;

  localparam int          MemSz    = 16;
  localparam int          MaxDelay = 10;
  localparam int          BurstLen = 4;
  localparam logic [15:0] Seed     = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] mode;
  logic [7:0] fixed_delay;
  logic [4:0] num_msgs;
  logic       rdy;
  logic       val;
  logic [7:0] msg;
  logic [4:0] count;
  logic       done;

  always #5 clk = ~clk;

  vc_test_rand_delay_source_ctrl #(
    .p_msg_sz   (8),
    .p_mem_sz   (MemSz),
    .p_max_delay(MaxDelay),
    .p_burst_len(BurstLen),
    .p_seed     (Seed)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .fixed_delay(fixed_delay),
    .num_msgs   (num_msgs),
    .val        (val),
    .rdy        (rdy),
    .msg        (msg),
    .count      (count),
    .done       (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] tbl [0:MemSz-1];
  bit         rdy_pat [0:511];

  // Model state: next message index, the cycle it becomes valid, handshakes so far.
  int          m_n, m_mode, m_fixed, m_k, m_ready, m_cnt, m_done_cyc;
  bit          m_done, m_rand_rdy;
  logic [15:0] m_lfsr;
  logic [7:0]  m_last;
  int          cyc;

  int first_val, first_done, val_cycles;
  int trace_sel = 0;
  int len_a = 0;
  bit trace_a [0:1023];
  bit trace_b [0:1023];

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int draw(input logic [15:0] s, input int k);
    int r;
    r = int'(s) % (MaxDelay + 1);
    case (m_mode)
      0:       return 0;
      1:       return m_fixed;
      2:       return r;
      default: return ((k % BurstLen) == 0) ? r : 0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_start();
    m_k = 0; m_cnt = 0; m_last = 8'h00; m_lfsr = Seed; cyc = 0;
    first_val = -1; first_done = -1; val_cycles = 0;
    if (m_n == 0) begin
      m_done = 1'b1; m_done_cyc = 1;
    end else begin
      m_done = 1'b0; m_ready = 1 + draw(Seed, 0);
    end
  endtask

  task automatic step(input string tag);
    bit         ev, ed, rc;
    logic [7:0] em;
    @(negedge clk);
    ev = !m_done && (cyc >= m_ready);
    ed = m_done && (cyc >= m_done_cyc);
    em = ev ? tbl[m_k] : m_last;
    check({tag, "_val"},   int'(val),   int'(ev));
    check({tag, "_done"},  int'(done),  int'(ed));
    check({tag, "_msg"},   int'(msg),   int'(em));
    check({tag, "_count"}, int'(count), m_cnt);
    if (val && first_val < 0) first_val = cyc;
    if (done && first_done < 0) first_done = cyc;
    if (val) val_cycles++;
    if (cyc < 1024) begin
      if (trace_sel == 1) trace_a[cyc] = val;
      if (trace_sel == 2) trace_b[cyc] = val;
    end
    if (ev) m_last = tbl[m_k];
    rc  = m_rand_rdy ? rdy_pat[cyc % 512] : 1'b1;
    rdy = rc;
    if (ev && rc) begin
      m_cnt++;
      if (m_cnt == m_n) begin
        m_done = 1'b1; m_done_cyc = cyc + 1;
      end else begin
        m_k++;
        m_ready = cyc + 1 + draw(m_lfsr, m_k);
      end
    end
    m_lfsr = lfsr_step(m_lfsr);
    cyc++;
  endtask

  task automatic run(input string tag, input int md, input int fd, input int nm,
                     input bit rr, input int stop_cnt);
    mode = md[1:0]; fixed_delay = fd[7:0]; num_msgs = nm[4:0];
    m_mode = md; m_fixed = fd; m_n = (nm > MemSz) ? MemSz : nm; m_rand_rdy = rr;
    reset = 1'b0; rdy = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_rst_val"},   int'(val),   0);
    check({tag, "_rst_done"},  int'(done),  0);
    check({tag, "_rst_msg"},   int'(msg),   0);
    check({tag, "_rst_count"}, int'(count), 0);
    @(posedge clk);
    #2 reset = 1'b1;
    model_start();
    while (1) begin
      step(tag);
      if (stop_cnt > 0 && m_cnt >= stop_cnt) break;
      if (m_done && cyc > m_done_cyc + 3) break;
      if (cyc >= 600) begin
        n_cmp++; n_bad++;
        $display("FAIL %s_timeout: got no completion by cycle %0d, expected done", tag, cyc);
        break;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected bench completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 512; i++) rdy_pat[i] = 1'($urandom_range(0, 1));
    tbl[0] = 8'haa; tbl[1] = 8'hbb; tbl[2] = 8'hcc;
    tbl[3] = 8'hdd; tbl[4] = 8'hee; tbl[5] = 8'hff;
    for (int i = 6; i < MemSz; i++) tbl[i] = 8'(8'h10 + i);
    for (int i = 0; i < MemSz; i++) dut.m[i] = tbl[i];
    mode = 2'd0; fixed_delay = 8'd0; num_msgs = 5'd0; rdy = 1'b0;

    check("lfsr_pin", int'(lfsr_step(Seed)), 'hE270);

    run("T1", 0, 0, 6, 1'b0, 0);
    check("T1_first_val", first_val, 1);
    check("T1_val_cycles", val_cycles, 6);
    check("T1_done_cyc", first_done, 7);

    run("T2", 1, 3, 3, 1'b0, 0);
    check("T2_first_val", first_val, 4);
    check("T2_val_cycles", val_cycles, 3);
    check("T2_done_cyc", first_done, 13);

    run("T3", 2, 0, 6, 1'b1, 0);
    check("T3_first_val", first_val, 5);
    check("T3_done_bound", int'(first_done >= 0 && first_done < 500), 1);

    // Gaps: 0xACE1 % 11 = 4 before group 0, 0xC2C4 % 11 = 8 before group 1.
    run("T4", 3, 0, 8, 1'b0, 0);
    check("T4_first_val", first_val, 5);
    check("T4_val_cycles", val_cycles, 8);
    check("T4_done_cyc", first_done, 21);

    run("T5", 0, 0, 0, 1'b0, 0);
    check("T5_val_cycles", val_cycles, 0);
    check("T5_done_cyc", first_done, 1);

    run("T7", 0, 0, 20, 1'b0, 0);
    check("T7_val_cycles", val_cycles, 16);
    check("T7_done_cyc", first_done, 17);

    trace_sel = 1;
    run("T6a", 2, 0, 6, 1'b1, 3);
    step("T6a");
    len_a = cyc;
    #2 reset = 1'b0;
    #1;
    check("T6_clr_val", int'(val), 0);
    check("T6_clr_done", int'(done), 0);
    check("T6_clr_count", int'(count), 0);
    check("T6_clr_msg", int'(msg), 0);
    trace_sel = 2;
    run("T6b", 2, 0, 6, 1'b1, 0);
    trace_sel = 0;
    for (int i = 0; i < len_a && i < 1024; i++) begin
      check("T6_replay_val", int'(trace_b[i]), int'(trace_a[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
